// File: rtl/pc_unit.sv
// pc_unit: program counter at the head of the fetch path.
//   Holds the current fetch address and advances it by sequential increment,
//   absolute jump, PC-relative branch, or call/return through an internal
//   return-address stack (RAS). Synchronous active-high reset loads RESET_ADDR.
//   Priority: rst_i > stall_i > op_i.
//
// Optional feature: define PC_MISALIGN_CHECK_EN to enable the registered
//   misalign flag (next PC not a multiple of STEP). Undefined: misalign_o = 0.
//
// Ports:
//   clk_i        clock, all state updates on rising edge
//   rst_i        synchronous active-high reset
//   stall_i      hold all state this cycle, op ignored
//   op_i         0=SEQ 1=JUMP 2=BRANCH 3=CALL 4=RET, 5..7 act as SEQ
//   target_i     absolute destination for JUMP/CALL
//   offset_i     two's-complement displacement for BRANCH
//   pc_o         current program counter (registered)
//   ras_empty_o  RAS holds no entries
//   ras_full_o   RAS holds RAS_DEPTH entries
//   ras_err_o    sticky overflow-push / underflow-pop indicator
//   misalign_o   current pc is not a multiple of STEP (optional)
module pc_unit #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned STEP       = 1,
  parameter int unsigned RESET_ADDR = 0,
  parameter int unsigned RAS_DEPTH  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] target_i,
  input  logic [WIDTH-1:0] offset_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             ras_empty_o,
  output logic             ras_full_o,
  output logic             ras_err_o,
  output logic             misalign_o
);

  localparam int unsigned      CW      = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_ADDR);
  localparam logic [CW-1:0]    DEPTH_W = CW'(RAS_DEPTH);

  localparam logic [2:0] OP_SEQ    = 3'd0;
  localparam logic [2:0] OP_JUMP   = 3'd1;
  localparam logic [2:0] OP_BRANCH = 3'd2;
  localparam logic [2:0] OP_CALL   = 3'd3;
  localparam logic [2:0] OP_RET    = 3'd4;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] top_addr;

  // Modulo-2^WIDTH sequential successor; also the CALL return address.
  assign seq_pc = pc_q + STEP_W;

  // Top-of-stack entry, selected by comparison to avoid index-width games.
  always_comb begin
    top_addr = '0;
    for (int i = 0; i < int'(RAS_DEPTH); i++) begin
      if (CW'(i) + CW'(1) == cnt_q) top_addr = ras_q[i];
    end
  end

  // Next-state for pc, stack and error flag.
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    err_d = err_q;
    ras_d = ras_q;
    if (!stall_i) begin
      case (op_i)
        OP_SEQ:    pc_d = seq_pc;
        OP_JUMP:   pc_d = target_i;
        OP_BRANCH: pc_d = pc_q + offset_i;
        OP_CALL: begin
          pc_d = target_i;
          if (cnt_q == DEPTH_W) begin
            err_d = 1'b1;
          end else begin
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
              if (CW'(i) == cnt_q) ras_d[i] = seq_pc;
            end
            cnt_d = cnt_q + CW'(1);
          end
        end
        OP_RET: begin
          if (cnt_q == '0) begin
            pc_d  = seq_pc;
            err_d = 1'b1;
          end else begin
            pc_d  = top_addr;
            cnt_d = cnt_q - CW'(1);
          end
        end
        default:   pc_d = seq_pc;
      endcase
    end
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == DEPTH_W);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= RESET_W;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  // Stack storage needs no reset; entries above the count are never read.
  always_ff @(posedge clk_i) begin
    ras_q <= ras_d;
  end

  assign pc_o        = pc_q;
  assign ras_empty_o = empty_q;
  assign ras_full_o  = full_q;
  assign ras_err_o   = err_q;

`ifdef PC_MISALIGN_CHECK_EN
  logic mis_q, mis_d;

  // STEP is a power of two, so low-bit mask gives next-PC mod STEP.
  always_comb begin
    mis_d = mis_q;
    if (!stall_i) mis_d = |(pc_d & (STEP_W - WIDTH'(1)));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) mis_q <= 1'b0;
    else       mis_q <= mis_d;
  end

  assign misalign_o = mis_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter block; successor to the plain 8-bit PC register.
- Adds:
  - synchronous reset to a programmable vector
  - stall
  - sequential increment
  - absolute jump and PC-relative branch
  - call/return through an internal return-address stack (RAS)
- Sits at the head of the fetch path; drives instruction-memory address; control unit drives op/target/offset.

Parameters:
- WIDTH, 8, address width in bits.
- STEP, 1, sequential increment; power of two, < 2^WIDTH.
- RESET_ADDR, 0, PC value loaded on reset.
- RAS_DEPTH, 4, return-address stack entries (>=1).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- stall  in  1  hold all state this cycle; op ignored.
- op  in  3  0=SEQ, 1=JUMP, 2=BRANCH, 3=CALL, 4=RET, 5..7 treated as SEQ.
- target  in  WIDTH  absolute destination for JUMP/CALL.
- offset  in  WIDTH  two's-complement displacement for BRANCH.
- pc  out  WIDTH  current program counter (registered).
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_err  out  1  sticky: overflow push or underflow pop occurred.
- misalign  out  1  see Optional Feature.

Behaviour:
- Clock clk; reset rst is synchronous, active-high. Priority: rst > stall > op.
- Reset values:
  - pc=RESET_ADDR
  - RAS count=0, so ras_empty=1, ras_full=0
  - ras_err=0, misalign=0
  - RAS entry contents don't-care.
- Reset asserted mid-operation (any op, any stack level) wins that edge; pending op is discarded.
- Latency: pc updates on the edge where op is sampled; new value visible the following cycle. No combinational path from inputs to pc.
- Next-PC, all arithmetic modulo 2^WIDTH, carries discarded:
  - SEQ: pc+STEP.
  - JUMP: target.
  - BRANCH: pc+offset. offset is signed, so offset=2^WIDTH-1 means -1.
  - CALL: pc<=target; push pc+STEP.
  - RET: pop; pc<=popped value.
- RAS: LIFO. Count register 0..RAS_DEPTH; ras_empty = (count==0); ras_full = (count==RAS_DEPTH).
- CALL when full:
  - pc<=target still taken.
  - Push discarded; stack contents and count unchanged.
  - ras_err<=1.
- RET when empty:
  - pc<=pc+STEP (behaves as SEQ); count stays 0.
  - ras_err<=1.
- ras_err is sticky until rst.
- stall=1: pc, RAS, count, ras_err, misalign all hold regardless of op/target/offset.
- Wrap-around: pc=2^WIDTH-STEP with SEQ gives 0; no flag raised.

Optional Feature:
- Macro: PC_MISALIGN_CHECK_EN.
- Defined:
  - On every non-stalled, non-reset edge, misalign<= (next-PC mod STEP != 0).
  - pc still loads the misaligned value; flag is registered, non-sticky, and describes the current pc.
  - When STEP=1, misalign is always 0.
- Undefined: misalign tied to constant 0; no checking logic instantiated.

Test Plan:
- Reset/sequence, WIDTH=8, STEP=1, RESET_ADDR=8'h10: rst=1 one edge, then 3 SEQ edges -> pc 10,11,12,13; ras_empty=1.
- Wrap, STEP=4: pc=8'hFC, SEQ -> pc=8'h00, ras_err=0. BRANCH with offset=8'hF8 from pc=8'h20 -> pc=8'h18.
- Call/return nest, RAS_DEPTH=4, from pc=8'h10:
  - CALL 8'h40 -> pc=40
  - CALL 8'h80 -> pc=80
  - RET -> pc=41
  - RET -> pc=11
  - ras_empty=1, ras_err=0.
- Overflow/underflow:
  - 5 consecutive CALLs -> 5th jumps, ras_full=1, ras_err=1; four RETs return the 4 pushed addresses in reverse order.
  - Extra RET -> pc+STEP, ras_err stays 1.
- Stall and reset priority:
  - stall=1 with op=JUMP, target=8'hAA for 3 cycles -> pc and RAS unchanged.
  - rst=1 with stall=1 and op=CALL -> pc=RESET_ADDR, count=0, ras_err=0.
- PC_MISALIGN_CHECK_EN defined, STEP=4: JUMP target=8'h22 -> pc=22, misalign=1; next SEQ -> pc=26, misalign=1; JUMP 8'h30 -> misalign=0. Undefined: misalign=0 throughout.
